// File: rtl/core_ctrl_fsm_if.sv
// Control bus between the core control FSM and the datapath/memory side.
// master = control FSM, slave = datapath and memory.
interface core_ctrl_fsm_if #(
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned STATE_W  = 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                branch_taken;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                mem_addr_sel;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                control_override;
    logic                alu_src_b;
    logic                reg_write;
    logic [1:0]          wb_sel;
    logic                instr_done;
    logic                illegal;
    logic [STATE_W-1:0]  state;

    modport master (
        input  opcode, branch_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               control_override, alu_src_b, reg_write, wb_sel, instr_done,
               illegal, state
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               control_override, alu_src_b, reg_write, wb_sel, instr_done,
               illegal, state
    );
endinterface

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the PhilosophyV core.
// Enables are Mealy/Moore decodes of the current state; illegal is a sticky register.
module core_ctrl_fsm #(
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned STATE_W  = 3
) (
    input  logic           clk,
    input  logic           rst,
    core_ctrl_fsm_if.master bus
);
    localparam logic [OPCODE_W-1:0] OP_LOAD    = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE   = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_ALU_IMM = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_ALU_REG = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_BRANCH  = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL     = OPCODE_W'(7'b1101111);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q;

    logic is_load, is_store, is_alu_imm, is_alu_reg, is_branch, is_jal, is_legal;

    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic       control_override, alu_src_b, reg_write, instr_done;
    logic [1:0] wb_sel;

    assign is_load    = (bus.opcode == OP_LOAD);
    assign is_store   = (bus.opcode == OP_STORE);
    assign is_alu_imm = (bus.opcode == OP_ALU_IMM);
    assign is_alu_reg = (bus.opcode == OP_ALU_REG);
    assign is_branch  = (bus.opcode == OP_BRANCH);
    assign is_jal     = (bus.opcode == OP_JAL);
    assign is_legal   = is_load | is_store | is_alu_imm | is_alu_reg | is_branch | is_jal;

    // State register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state and enable decode
    always_comb begin
        state_d          = state_q;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr_sel     = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = 1'b0;
        control_override = 1'b1;
        alu_src_b        = 1'b0;
        reg_write        = 1'b0;
        wb_sel           = 2'd0;
        instr_done       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = is_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_alu_reg || is_alu_imm) begin
                    control_override = 1'b0;
                    alu_src_b        = is_alu_imm;
                    state_d          = S_WB;
                end else if (is_load || is_store) begin
                    alu_src_b = 1'b1;
                    state_d   = S_MEM;
                end else if (is_branch) begin
                    pc_write   = bus.branch_taken;
                    pc_src     = bus.branch_taken;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_jal) begin
                    reg_write  = 1'b1;
                    wb_sel     = 2'd2;
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    // IR is stable after DECODE, so this only guards against corruption
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                if (bus.mem_ready) begin
                    if (is_store) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write        = 1'b1;
                wb_sel           = is_load ? 2'd1 : 2'd0;
                control_override = ~(is_alu_reg | is_alu_imm);
                instr_done       = 1'b1;
                state_d          = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset cycle presents the idle output set regardless of state
        if (rst) begin
            mem_req          = 1'b0;
            mem_we           = 1'b0;
            mem_addr_sel     = 1'b0;
            ir_write         = 1'b0;
            pc_write         = 1'b0;
            pc_src           = 1'b0;
            control_override = 1'b1;
            alu_src_b        = 1'b0;
            reg_write        = 1'b0;
            wb_sel           = 2'd0;
            instr_done       = 1'b0;
        end
    end

    assign bus.mem_req          = mem_req;
    assign bus.mem_we           = mem_we;
    assign bus.mem_addr_sel     = mem_addr_sel;
    assign bus.ir_write         = ir_write;
    assign bus.pc_write         = pc_write;
    assign bus.pc_src           = pc_src;
    assign bus.control_override = control_override;
    assign bus.alu_src_b        = alu_src_b;
    assign bus.reg_write        = reg_write;
    assign bus.wb_sel           = wb_sel;
    assign bus.instr_done       = instr_done;
    assign bus.illegal          = illegal_q;
    assign bus.state            = STATE_W'(state_q);
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Bench for core_ctrl_fsm: per-instruction expected cycle plans built from the
// instruction-class timing rules, compared every cycle, plus literal state traces.
module tb_core_ctrl_fsm;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       ctrl_ovr;
        logic       alu_src_b;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       instr_done;
        logic       illegal;
    } exp_t;

    typedef struct packed {
        logic [6:0] op;
        logic       rdy;
        logic       bt;
        logic       rst;
        exp_t       e;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;
    core_ctrl_fsm_if #(.OPCODE_W(7), .STATE_W(3)) bus ();
    core_ctrl_fsm #(.OPCODE_W(7), .STATE_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    cyc_t plan[$];
    exp_t cur;
    exp_t got;
    bit   exp_valid = 1'b0;
    bit   last = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    bit   lit_on = 1'b0;
    int   lit_st[$];
    int   lit_req;
    int   lit_ill;
    int   tr_st[$];
    int   tr_req = 0;

    logic [6:0] legal_ops [6] = '{OP_LOAD, OP_STORE, OP_ALU_IMM, OP_ALU_REG, OP_BRANCH, OP_JAL};

    function automatic bit is_legal(logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_ALU_IMM ||
               op == OP_ALU_REG || op == OP_BRANCH || op == OP_JAL;
    endfunction

    function automatic exp_t idle(logic [2:0] st, logic ill);
        exp_t e;
        e = '0;
        e.state = st;
        e.ctrl_ovr = 1'b1;
        e.illegal = ill;
        return e;
    endfunction

    task automatic push(logic [6:0] op, logic rdy, logic bt, exp_t e);
        cyc_t c;
        c.op = op; c.rdy = rdy; c.bt = bt; c.rst = 1'b0; c.e = e;
        plan.push_back(c);
    endtask

    // Expected cycle list for one instruction, from the class timing rules
    task automatic build(logic [6:0] op, logic bt, int fw, int mw, int trap_n);
        exp_t e;
        bit ld, st, alu, mem;
        ld  = (op == OP_LOAD);
        st  = (op == OP_STORE);
        alu = (op == OP_ALU_REG) || (op == OP_ALU_IMM);
        mem = ld || st;
        plan.delete();
        for (int i = 0; i < fw; i++) begin
            e = idle(3'd0, 1'b0); e.mem_req = 1'b1;
            push(7'($urandom), 1'b0, 1'($urandom), e);
        end
        e = idle(3'd0, 1'b0); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(7'($urandom), 1'b1, 1'($urandom), e);
        push(op, 1'($urandom), 1'($urandom), idle(3'd1, 1'b0));
        if (!is_legal(op)) begin
            for (int i = 0; i < trap_n; i++) push(op, 1'($urandom), 1'($urandom), idle(3'd7, 1'b1));
            return;
        end
        e = idle(3'd2, 1'b0);
        if (alu) begin
            e.ctrl_ovr = 1'b0; e.alu_src_b = (op == OP_ALU_IMM);
        end else if (mem) begin
            e.alu_src_b = 1'b1;
        end else if (op == OP_BRANCH) begin
            e.pc_write = bt; e.pc_src = bt; e.instr_done = 1'b1;
        end else begin
            e.reg_write = 1'b1; e.wb_sel = 2'd2; e.pc_write = 1'b1; e.pc_src = 1'b1; e.instr_done = 1'b1;
        end
        push(op, 1'($urandom), bt, e);
        if (mem) begin
            e = idle(3'd3, 1'b0); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = st;
            for (int i = 0; i < mw; i++) push(op, 1'b0, 1'($urandom), e);
            e.instr_done = st;
            push(op, 1'b1, 1'($urandom), e);
        end
        if (alu || ld) begin
            e = idle(3'd4, 1'b0); e.reg_write = 1'b1; e.wb_sel = ld ? 2'd1 : 2'd0;
            e.ctrl_ovr = ld; e.instr_done = 1'b1;
            push(op, 1'($urandom), 1'($urandom), e);
        end
    endtask

    task automatic append_rst(logic [2:0] st, logic ill);
        cyc_t c;
        c = plan[plan.size() - 1];
        c.rst = 1'b1; c.rdy = 1'($urandom); c.e = idle(st, ill);
        plan.push_back(c);
    endtask

    // Replace cycle k with a reset cycle and drop the rest of the instruction
    task automatic abort_at(int k);
        cyc_t c;
        c = plan[k];
        while (plan.size() > k) void'(plan.pop_back());
        c.rst = 1'b1;
        c.e = idle(c.e.state, c.e.illegal);
        plan.push_back(c);
    endtask

    task automatic run();
        for (int i = 0; i < plan.size(); i++) begin
            @(posedge clk); #1;
            rst = plan[i].rst;
            bus.opcode = plan[i].op;
            bus.mem_ready = plan[i].rdy;
            bus.branch_taken = plan[i].bt;
            cur = plan[i].e;
            last = (i == plan.size() - 1);
            exp_valid = 1'b1;
        end
        @(negedge clk); #1;
    endtask

    task automatic check_vec(exp_t g, exp_t x);
        n_chk++;
        if (g === x) n_pass++;
        else $display("FAIL outputs t=%0t got=%h exp=%h (got state=%0d exp state=%0d)",
                      $time, g, x, g.state, x.state);
    endtask

    task automatic check_int(string name, int g, int x);
        n_chk++;
        if (g == x) n_pass++;
        else $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, g, x);
    endtask

    // Single compare process: model check every cycle, literal trace check at plan end
    always @(negedge clk) begin
        if (exp_valid) begin
            got = '0;
            got.state = bus.state;
            got.mem_req = bus.mem_req;
            got.mem_we = bus.mem_we;
            got.mem_addr_sel = bus.mem_addr_sel;
            got.ir_write = bus.ir_write;
            got.pc_write = bus.pc_write;
            got.pc_src = bus.pc_src;
            got.ctrl_ovr = bus.control_override;
            got.alu_src_b = bus.alu_src_b;
            got.reg_write = bus.reg_write;
            got.wb_sel = bus.wb_sel;
            got.instr_done = bus.instr_done;
            got.illegal = bus.illegal;
            check_vec(got, cur);
            if (lit_on) begin
                tr_st.push_back(int'(bus.state));
                tr_req += int'(bus.mem_req);
            end
            if (last && lit_on) begin
                check_int("lit_len", tr_st.size(), lit_st.size());
                for (int i = 0; i < lit_st.size() && i < tr_st.size(); i++)
                    check_int("lit_state", tr_st[i], lit_st[i]);
                check_int("lit_req", tr_req, lit_req);
                check_int("lit_illegal", int'(bus.illegal), lit_ill);
            end
            if (last) begin
                tr_st.delete();
                tr_req = 0;
            end
        end
    end

    initial begin
        int pick;
        logic [6:0] op;
        rst = 1'b1;
        bus.opcode = '0;
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        repeat (2) @(posedge clk);

        lit_on = 1'b1;
        lit_st = '{0, 1, 2, 4}; lit_req = 1; lit_ill = 0;
        build(OP_ALU_REG, 1'b0, 0, 0, 0); run();

        lit_st = '{0, 0, 0, 1, 2, 3, 3, 3, 4}; lit_req = 6; lit_ill = 0;
        build(OP_LOAD, 1'b0, 2, 2, 0); run();

        lit_st = '{0, 1, 2, 3, 3}; lit_req = 3; lit_ill = 0;
        build(OP_STORE, 1'b0, 0, 1, 0); run();

        lit_st = '{0, 1, 2}; lit_req = 1; lit_ill = 0;
        build(OP_BRANCH, 1'b1, 0, 0, 0); run();
        build(OP_BRANCH, 1'b0, 0, 0, 0); run();
        build(OP_JAL, 1'b0, 0, 0, 0); run();

        lit_st = '{0, 1, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7}; lit_req = 1; lit_ill = 1;
        build(7'b0001111, 1'b0, 0, 0, 10); append_rst(3'd7, 1'b1); run();

        lit_st = '{0, 1, 2, 3, 3}; lit_req = 2; lit_ill = 0;
        build(OP_LOAD, 1'b0, 0, 3, 0); abort_at(4); run();

        lit_st = '{0, 1, 2, 4}; lit_req = 1; lit_ill = 0;
        build(OP_ALU_IMM, 1'b0, 0, 0, 0); run();
        lit_on = 1'b0;

        for (int n = 0; n < 400; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 8) op = legal_ops[$urandom_range(0, 5)];
            else op = 7'($urandom);
            build(op, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(1, 4)));
            if (!is_legal(op)) append_rst(3'd7, 1'b1);
            else if ($urandom_range(0, 9) == 0) abort_at(int'($urandom_range(0, plan.size() - 1)));
            run();
        end

        @(posedge clk); #1;
        exp_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
